// File: rtl/bcd_display_reader_if.sv
// Bundles the display reader's result-load handshake and its display pin outputs.
// The master side is the result register, and the slave side is the display reader.
interface bcd_display_reader_if #(
  parameter int WORD_LENGTH = 8,
  parameter int DIGITS      = 3
);
  logic [WORD_LENGTH-1:0] Data_Input;
  logic                   Load;
  logic                   Signed;
  logic                   Busy;
  logic                   Done;
  logic                   Negative;
  logic [6:0]             Segments;
  logic [DIGITS-1:0]      Anodes;

  modport master (
    output Data_Input, Load, Signed,
    input  Busy, Done, Negative, Segments, Anodes
  );

  modport slave (
    input  Data_Input, Load, Signed,
    output Busy, Done, Negative, Segments, Anodes
  );
endinterface

// File: rtl/bcd_display_reader.sv
// Captures a binary result and converts it to BCD with a shift-add-3 engine.
// Scans the digits onto a common-anode 7-segment display and blanks leading zeros.
//
// state   | meaning
// IDLE    | display holds the last value; Load starts a capture
// CONVERT | one add-3/shift step per cycle until all bits are shifted
module bcd_display_reader #(
  parameter int WORD_LENGTH = 8,
  parameter int DIGITS      = 3,
  parameter int SCAN_DIV    = 4
) (
  input logic                 clk,
  input logic                 reset,
  bcd_display_reader_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WORD_LENGTH + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SHIFTS    = CW'(WORD_LENGTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [SW-1:0] LAST_SCAN = SW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                 state, state_nxt;
  logic [WORD_LENGTH-1:0] bin_q;
  logic [BW-1:0]          bcd_q;
  logic [BW-1:0]          disp_q;
  logic [CW-1:0]          shifts_left;
  logic                   sign_q;
  logic                   neg_q;
  logic                   done_q;

  logic                   capture;
  logic                   last_shift;
  logic [WORD_LENGTH-1:0] magnitude;
  logic [BW-1:0]          bcd_adj;
  logic [BW+WORD_LENGTH-1:0] shifted;
  logic [BW-1:0]          bcd_shift;
  logic [WORD_LENGTH-1:0] bin_shift;
  logic [BW-1:0]          disp_nxt;

  logic [SW-1:0]          scan_cnt;
  logic [IW-1:0]          digit_idx;
  logic [IW-1:0]          idx_nxt;
  logic                   scan_wrap;
  logic [DIGITS-1:0]      blank;
  logic                   zero_above;
  logic [3:0]             active_digit;
  logic                   active_blank;
  logic [6:0]             segments_q;
  logic [DIGITS-1:0]      anodes_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    last_shift = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Load) begin
          capture   = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (shifts_left == CW'(1)) begin
          last_shift = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitude of the incoming word; the most-negative value maps to 2^(WORD_LENGTH-1).
  always_comb begin
    magnitude = bus.Data_Input;
    if (bus.Signed && bus.Data_Input[WORD_LENGTH-1])
      magnitude = ~bus.Data_Input + WORD_LENGTH'(1);
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
    shifted   = {bcd_adj, bin_q} << 1;
    bcd_shift = shifted[BW+WORD_LENGTH-1 -: BW];
    bin_shift = shifted[WORD_LENGTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      shifts_left <= '0;
      sign_q      <= 1'b0;
    end else if (capture) begin
      bin_q       <= magnitude;
      bcd_q       <= '0;
      shifts_left <= SHIFTS;
      sign_q      <= bus.Signed & bus.Data_Input[WORD_LENGTH-1];
    end else if (state == CONVERT) begin
      bin_q       <= bin_shift;
      bcd_q       <= bcd_shift;
      shifts_left <= shifts_left - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_shift;
      if (last_shift) begin
        disp_q <= bcd_shift;
        neg_q  <= sign_q && (bcd_shift != '0);
      end
    end
  end

  // The scan decodes the value being written this edge, so a new result shows with Done.
  assign disp_nxt  = last_shift ? bcd_shift : disp_q;
  assign scan_wrap = (scan_cnt == LAST_SCAN);

  always_comb begin
    idx_nxt = digit_idx;
    if (scan_wrap)
      idx_nxt = (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
  end

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_nxt[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  always_comb begin
    active_digit = 4'd0;
    active_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        active_digit = disp_nxt[4*i +: 4];
        active_blank = blank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      segments_q <= 7'h40;
      anodes_q   <= ~DIGITS'(1);
    end else begin
      scan_cnt   <= scan_wrap ? '0 : scan_cnt + SW'(1);
      digit_idx  <= idx_nxt;
      segments_q <= active_blank ? 7'h7F : seg_decode(active_digit);
      anodes_q   <= ~(DIGITS'(1) << idx_nxt);
    end
  end

  assign bus.Busy     = (state == CONVERT);
  assign bus.Done     = done_q;
  assign bus.Negative = neg_q;
  assign bus.Segments = segments_q;
  assign bus.Anodes   = anodes_q;

endmodule

// File: tb/tb_bcd_display_reader.sv
// Self-checking bench for bcd_display_reader: directed cases plus random loads,
// checked against a decimal-arithmetic model of the expected display.
module tb_bcd_display_reader;
  localparam int WL = 8;
  localparam int DG = 3;
  localparam int SD = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bcd_display_reader_if #(.WORD_LENGTH(WL), .DIGITS(DG)) bus ();

  bcd_display_reader #(.WORD_LENGTH(WL), .DIGITS(DG), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int exp_seg(input int mag, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (i > 0 && mag < p) return 'h7F;
    return int'(SEG_TAB[(mag / p) % 10]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int v, input bit s);
    bus.Data_Input = v[WL-1:0];
    bus.Signed     = s;
    bus.Load       = 1'b1;
    step();
    bus.Load       = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic convert(input string tag, input int v, input bit s);
    int c;
    start_load(v, s);
    check({tag, "_busy"}, int'(bus.Busy), 1);
    wait_done(c);
    check({tag, "_latency"}, c, WL);
    check({tag, "_busy_done"}, int'(bus.Busy), 0);
  endtask

  task automatic check_display(input string tag, input int mag, input bit neg);
    int segs [DG];
    int bad, extra, idx;
    bad   = 0;
    extra = 0;
    for (int i = 0; i < DG; i++) segs[i] = -1;
    check({tag, "_neg"}, int'(bus.Negative), int'(neg));
    for (int t = 0; t < 2 * DG * SD; t++) begin
      idx = -1;
      for (int i = 0; i < DG; i++)
        if (bus.Anodes == ~(DG'(1) << i)) idx = i;
      if (idx < 0) bad++;
      else segs[idx] = int'(bus.Segments);
      step();
      if (bus.Done) extra++;
    end
    check({tag, "_anodes"}, bad, 0);
    check({tag, "_extra_done"}, extra, 0);
    for (int i = 0; i < DG; i++)
      check($sformatf("%s_d%0d", tag, i), segs[i], exp_seg(mag, i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, v, j, mag;
    bit s, neg;
    bus.Data_Input = '0;
    bus.Load       = 1'b0;
    bus.Signed     = 1'b0;

    // Reset state and first scan step
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_segments", int'(bus.Segments), 'h40);
    check("rst_anodes", int'(bus.Anodes), 'b110);
    check("rst_busy", int'(bus.Busy), 0);
    check("rst_done", int'(bus.Done), 0);
    check("rst_neg", int'(bus.Negative), 0);
    repeat (SD) step();
    check("rst_scan_anodes", int'(bus.Anodes), 'b101);
    check("rst_scan_blank", int'(bus.Segments), 'h7F);

    convert("u237", 237, 1'b0);   check_display("u237", 237, 1'b0);
    convert("sF6", 'hF6, 1'b1);   check_display("sF6", 10, 1'b1);
    convert("s80", 'h80, 1'b1);   check_display("s80", 128, 1'b1);
    convert("u5", 5, 1'b0);       check_display("u5", 5, 1'b0);
    convert("s0", 0, 1'b1);       check_display("s0", 0, 1'b0);

    // Load during conversion is ignored
    start_load(99, 1'b0);
    step();
    step();
    bus.Data_Input = 8'd42;
    bus.Load       = 1'b1;
    step();
    bus.Load       = 1'b0;
    wait_done(c);
    check("ign_latency", c, WL - 3);
    check_display("ign99", 99, 1'b0);

    // Load in the Done cycle is accepted
    start_load(99, 1'b0);
    wait_done(c);
    check("dc_first_latency", c, WL);
    convert("dc42", 42, 1'b0);
    check_display("dc42", 42, 1'b0);

    // Reset mid-conversion
    start_load(200, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("mid_rst_segments", int'(bus.Segments), 'h40);
    check("mid_rst_anodes", int'(bus.Anodes), 'b110);
    check("mid_rst_busy", int'(bus.Busy), 0);
    step();
    reset = 1'b1;
    check_display("mid_rst_zero", 0, 1'b0);
    convert("u17", 17, 1'b0);
    check_display("u17", 17, 1'b0);

    // Random loads, some with an ignored Load mid-conversion
    for (int n = 0; n < 25; n++) begin
      v   = int'($urandom_range(0, 255));
      s   = 1'($urandom_range(0, 1));
      neg = s && (v >= 128);
      mag = neg ? 256 - v : v;
      if ($urandom_range(0, 3) == 0) begin
        start_load(v, s);
        j = int'($urandom_range(1, 6));
        repeat (j) step();
        bus.Data_Input = 8'($urandom_range(0, 255));
        bus.Signed     = 1'($urandom_range(0, 1));
        bus.Load       = 1'b1;
        step();
        bus.Load       = 1'b0;
        wait_done(c);
        check($sformatf("rnd%0d_latency", n), c, WL - j - 1);
      end else begin
        convert($sformatf("rnd%0d", n), v, s);
      end
      check_display($sformatf("rnd%0d_v%0d", n, v), mag, neg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
